ptch_pd_math: RTL and testbench

//  Consumes fused pitch samples from the inertial interface (vld/ptch) and the commanded pitch.

---
 rtl/ptch_pd_math.sv | 109 ++++++++++
 tb/tb_ptch_pd_math.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ptch_pd_math.sv
// Pitch PD math: saturates the pitch error, keeps a circular error history for the
// derivative and registers the P/D terms with a single-cycle pd_vld strobe.
module ptch_pd_math #(
  parameter int unsigned D_QUEUE_DEPTH = 12,
  parameter logic [3:0]  P_COEFF       = 4'd5,
  parameter logic [3:0]  D_COEFF       = 4'd7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vld,
  input  logic [15:0] actual,
  input  logic [15:0] desired,
  input  logic        clr,
  output logic [13:0] pterm,
  output logic [10:0] dterm,
  output logic        pd_vld
);

  localparam int unsigned   PW   = (D_QUEUE_DEPTH > 1) ? $clog2(D_QUEUE_DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(D_QUEUE_DEPTH - 1);

  logic signed [16:0] w_err;
  logic signed [9:0]  w_err_sat;

  logic signed [9:0]  r_err_q;
  logic               r_s1_vld;

  logic signed [9:0]  r_queue [D_QUEUE_DEPTH];
  logic [PW-1:0]      r_wptr;
  logic signed [9:0]  w_prev;
  logic signed [10:0] w_diff;
  logic signed [6:0]  w_diff_sat;
  logic signed [13:0] w_pterm;
  logic signed [10:0] w_dterm;

  logic signed [13:0] r_pterm;
  logic signed [10:0] r_dterm;
  logic               r_pd_vld;

  // 17-bit difference cannot overflow for any pair of 16-bit signed inputs
  assign w_err = $signed({actual[15], actual}) - $signed({desired[15], desired});

  always_comb begin
    if (w_err > 17'sd511)
      w_err_sat = 10'sd511;
    else if (w_err < -17'sd512)
      w_err_sat = -10'sd512;
    else
      w_err_sat = w_err[9:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_err_q  <= '0;
    end else if (clr) begin
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_vld <= vld;
      if (vld)
        r_err_q <= w_err_sat;
    end
  end

  assign w_prev = r_queue[r_wptr];
  assign w_diff = 11'(r_err_q) - 11'(w_prev);

  always_comb begin
    if (w_diff > 11'sd63)
      w_diff_sat = 7'sd63;
    else if (w_diff < -11'sd64)
      w_diff_sat = -7'sd64;
    else
      w_diff_sat = w_diff[6:0];
  end

  // Gains are unsigned; zero-extend them before the signed multiply
  assign w_pterm = 14'(r_err_q) * $signed(14'(P_COEFF));
  assign w_dterm = 11'(w_diff_sat) * $signed(11'(D_COEFF));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < D_QUEUE_DEPTH; i++)
        r_queue[i] <= '0;
      r_wptr   <= '0;
      r_pterm  <= '0;
      r_dterm  <= '0;
      r_pd_vld <= 1'b0;
    end else if (clr) begin
      for (int unsigned i = 0; i < D_QUEUE_DEPTH; i++)
        r_queue[i] <= '0;
      r_wptr   <= '0;
      r_pd_vld <= 1'b0;
    end else if (r_s1_vld) begin
      r_queue[r_wptr] <= r_err_q;
      r_wptr          <= (r_wptr == LAST) ? '0 : r_wptr + PW'(1);
      r_pterm         <= w_pterm;
      r_dterm         <= w_dterm;
      r_pd_vld        <= 1'b1;
    end else begin
      r_pd_vld <= 1'b0;
    end
  end

  assign pterm  = r_pterm;
  assign dterm  = r_dterm;
  assign pd_vld = r_pd_vld;

endmodule

// File: tb/tb_ptch_pd_math.sv
// Bench for ptch_pd_math: directed vector table, hand-written corner sequences and a
// randomized run, all checked against an error-history reference model.
module tb_ptch_pd_math;

  localparam int DEPTH = 12;
  localparam int PC    = 5;
  localparam int DC    = 7;

  logic        clk = 1'b0;
  logic        rst, vld, clr;
  logic [15:0] actual, desired;
  logic [13:0] pterm;
  logic [10:0] dterm;
  logic        pd_vld;

  always #5 clk = ~clk;

  ptch_pd_math #(
    .D_QUEUE_DEPTH(DEPTH),
    .P_COEFF      (4'd5),
    .D_COEFF      (4'd7)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .vld    (vld),
    .actual (actual),
    .desired(desired),
    .clr    (clr),
    .pterm  (pterm),
    .dterm  (dterm),
    .pd_vld (pd_vld)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: accepted sample errors since the last flush, newest at the back
  int hist[$];
  int m_p = 0, m_d = 0, m_v = 0;
  bit pend = 1'b0;
  int perr = 0;

  typedef struct {
    int a;
    int d;
    int p;
    int dt;
  } vec_t;
  vec_t tbl[13];

  function automatic int sat(int x, int lo, int hi);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit v, input int a, input int d, input bit c);
    int ea, ed, prev;
    rst     = r;
    vld     = v;
    actual  = a[15:0];
    desired = d[15:0];
    clr     = c;
    ea = int'($signed(actual));
    ed = int'($signed(desired));
    @(posedge clk);
    if (r) begin
      hist.delete();
      pend = 1'b0;
      m_p = 0; m_d = 0; m_v = 0;
    end else if (c) begin
      hist.delete();
      pend = 1'b0;
      m_v = 0;
    end else begin
      if (pend) begin
        prev = (hist.size() == DEPTH) ? hist[0] : 0;
        hist.push_back(perr);
        if (hist.size() > DEPTH) void'(hist.pop_front());
        m_p = perr * PC;
        m_d = sat(perr - prev, -64, 63) * DC;
        m_v = 1;
      end else begin
        m_v = 0;
      end
      pend = v;
      if (v) perr = sat(ea - ed, -512, 511);
    end
    #1;
    check("model_pd_vld", int'(pd_vld), m_v);
    check("model_pterm", int'($signed(pterm)), m_p);
    check("model_dterm", int'($signed(dterm)), m_d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{100,    0,      500,   441};
    tbl[1]  = '{32767,  -32768, 2555,  441};
    tbl[2]  = '{-32768, 32767,  -2560, -448};
    tbl[3]  = '{0,      0,      0,     0};
    tbl[4]  = '{5,      10,     -25,   -35};
    tbl[5]  = '{511,    0,      2555,  441};
    tbl[6]  = '{-600,   0,      -2560, -448};
    tbl[7]  = '{63,     0,      315,   441};
    tbl[8]  = '{64,     0,      320,   441};
    tbl[9]  = '{-64,    0,      -320,  -448};
    tbl[10] = '{-65,    0,      -325,  -448};
    tbl[11] = '{10,     3,      35,    49};
    tbl[12] = '{-5,     -7,     10,    14};

    // Reset with random inputs, then idle
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), int'($urandom), int'($urandom), 1'($urandom_range(0, 1)));
      check("rst_pterm", int'($signed(pterm)), 0);
      check("rst_dterm", int'($signed(dterm)), 0);
      check("rst_pd_vld", int'(pd_vld), 0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, int'($urandom), int'($urandom), 1'b0);
      check("idle_pd_vld", int'(pd_vld), 0);
    end

    // Single samples from a flushed history
    foreach (tbl[i]) begin
      step(1'b0, 1'b0, 0, 0, 1'b1);
      step(1'b0, 1'b1, tbl[i].a, tbl[i].d, 1'b0);
      check("tbl_latency", int'(pd_vld), 0);
      step(1'b0, 1'b0, 0, 0, 1'b0);
      check("tbl_pd_vld", int'(pd_vld), 1);
      check("tbl_pterm", int'($signed(pterm)), tbl[i].p);
      check("tbl_dterm", int'($signed(dterm)), tbl[i].dt);
      step(1'b0, 1'b0, 0, 0, 1'b0);
      check("tbl_pulse", int'(pd_vld), 0);
      check("tbl_hold", int'($signed(pterm)), tbl[i].p);
    end

    // 13 spaced samples of err=20: priming then the first history hit
    step(1'b0, 1'b0, 0, 0, 1'b1);
    for (int k = 1; k <= 13; k++) begin
      step(1'b0, 1'b1, 20, 0, 1'b0);
      step(1'b0, 1'b0, 0, 0, 1'b0);
      check("prime_pterm", int'($signed(pterm)), 100);
      check("prime_dterm", int'($signed(dterm)), (k <= 12) ? 140 : 0);
    end

    // clr discards a coincident vld and flushes the history
    step(1'b0, 1'b0, 0, 0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 40, 0, 1'b0);
      step(1'b0, 1'b0, 0, 0, 1'b0);
    end
    step(1'b0, 1'b1, 40, 0, 1'b1);
    check("clr_pd_vld", int'(pd_vld), 0);
    check("clr_hold_p", int'($signed(pterm)), 200);
    step(1'b0, 1'b0, 0, 0, 1'b0);
    check("clr_drop", int'(pd_vld), 0);
    step(1'b0, 1'b1, 40, 0, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b0);
    check("clr_after_vld", int'(pd_vld), 1);
    check("clr_after_dterm", int'($signed(dterm)), 280);

    // Back-to-back ramp across the queue wrap, then reset mid-stream
    step(1'b0, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b1, i, 0, 1'b0);
      if (i >= 1) check("ramp_pd_vld", int'(pd_vld), 1);
      if (i >= 13) check("ramp_dterm", int'($signed(dterm)), 84);
    end
    step(1'b1, 1'b1, 100, 0, 1'b0);
    check("midrst_pterm", int'($signed(pterm)), 0);
    check("midrst_dterm", int'($signed(dterm)), 0);
    check("midrst_pd_vld", int'(pd_vld), 0);
    step(1'b0, 1'b1, 5, 0, 1'b0);
    check("midrst_drop", int'(pd_vld), 0);
    step(1'b0, 1'b0, 0, 0, 1'b0);
    check("midrst_next_p", int'($signed(pterm)), 25);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit big;
      int a, d;
      big = ($urandom_range(0, 3) == 0);
      a = big ? int'($urandom) : int'($urandom_range(0, 1400)) - 700;
      d = big ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 9) < 6), a, d,
           ($urandom_range(0, 59) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
